// File: rtl/pe_unit_gen2_if.sv
// Systolic PE neighbour bus: west activation in / east activation out,
// north operand-psum in / south operand-psum out, each valid-qualified.
//   master : drives a_in/b_in and their valids, observes a_out/b_out.
//   slave  : the PE side; consumes inputs and drives the registered outputs.
interface pe_unit_gen2_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACCUM_WIDTH = 24
);
    logic [DATA_WIDTH-1:0]  a_in;
    logic                   a_in_valid;
    logic [ACCUM_WIDTH-1:0] b_in;
    logic                   b_in_valid;
    logic [DATA_WIDTH-1:0]  a_out;
    logic                   a_out_valid;
    logic [ACCUM_WIDTH-1:0] b_out;
    logic                   b_out_valid;

    modport master (
        output a_in, a_in_valid, b_in, b_in_valid,
        input  a_out, a_out_valid, b_out, b_out_valid
    );

    modport slave (
        input  a_in, a_in_valid, b_in, b_in_valid,
        output a_out, a_out_valid, b_out, b_out_valid
    );
endinterface

// File: rtl/pe_unit_gen2.sv
// Processing element for the reconfigurable systolic array. Supports
// weight-stationary, output-stationary and bypass dataflow with saturating
// accumulation and sticky overflow / protocol-error flags. All outputs are
// registered (one hop per cycle).
// Ports:
//   clk, reset          : clock, async active-high reset
//   bus (slave)         : a_in/b_in valid-qualified inputs, a_out/b_out outputs
//   mode                : 0 WS, 1 OS, 2/3 BYPASS
//   stall               : freeze every register
//   weight_in/_load     : stationary weight load
//   acc_clear, drain    : OS accumulator clear / emit
//   acc_ovf, proto_err  : sticky status flags
module pe_unit_gen2 #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACCUM_WIDTH = 24,
    parameter bit          SIGNED      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    pe_unit_gen2_if.slave         bus,
    input  logic [1:0]            mode,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  weight_load,
    input  logic                  acc_clear,
    input  logic                  drain,
    output logic                  acc_ovf,
    output logic                  proto_err
);
    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned AW     = ACCUM_WIDTH;
    localparam int unsigned EXT_W  = AW + 1;
    localparam int unsigned PROD_W = 2 * DW + 2;

    typedef enum logic [1:0] {
        MODE_WS  = 2'd0,
        MODE_OS  = 2'd1,
        MODE_BYP = 2'd2
    } mode_e;

    mode_e          eff_mode;
    mode_e          mode_q, mode_d;
    logic [DW-1:0]  a_out_q, a_out_d;
    logic           a_out_valid_q, a_out_valid_d;
    logic [AW-1:0]  b_out_q, b_out_d;
    logic           b_out_valid_q, b_out_valid_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [DW-1:0]  weight_q, weight_d;
    logic           acc_ovf_q, acc_ovf_d;
    logic           proto_err_q, proto_err_d;

    logic                     fire;
    logic [DW-1:0]            operand;
    logic signed [DW:0]       a_ext, op_ext;
    logic signed [PROD_W-1:0] prod_full;
    logic [EXT_W-1:0]         prod_ext;
    logic [AW-1:0]            add_base;
    logic [EXT_W-1:0]         base_ext, sum;
    logic [AW-1:0]            sat_val;
    logic                     clamp;

    // Shared multiply / saturating adder: WS adds to the incoming psum,
    // OS adds to the accumulator (zero when a clear coincides with a fire).
    always_comb begin
        eff_mode  = (mode == 2'd3) ? MODE_BYP : mode_e'(mode);
        fire      = bus.a_in_valid & bus.b_in_valid;
        operand   = (eff_mode == MODE_WS) ? weight_q : bus.b_in[DW-1:0];
        a_ext     = {SIGNED & bus.a_in[DW-1], bus.a_in};
        op_ext    = {SIGNED & operand[DW-1], operand};
        prod_full = PROD_W'(a_ext) * PROD_W'(op_ext);
        prod_ext  = EXT_W'(prod_full);
        if (eff_mode == MODE_WS) begin
            add_base = bus.b_in;
        end else if (acc_clear) begin
            add_base = '0;
        end else begin
            add_base = acc_q;
        end
        base_ext = {SIGNED & add_base[AW-1], add_base};
        sum      = base_ext + prod_ext;
        if (SIGNED) begin
            // Signed overflow when the extra sign bit disagrees with the MSB.
            clamp   = sum[AW] ^ sum[AW-1];
            sat_val = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            clamp   = sum[AW];
            sat_val = '1;
        end
        if (!clamp) begin
            sat_val = sum[AW-1:0];
        end
    end

    // Next-state for every register; stall leaves all defaults (hold).
    always_comb begin
        mode_d        = mode_q;
        a_out_d       = a_out_q;
        a_out_valid_d = a_out_valid_q;
        b_out_d       = b_out_q;
        b_out_valid_d = b_out_valid_q;
        acc_d         = acc_q;
        weight_d      = weight_q;
        acc_ovf_d     = acc_ovf_q;
        proto_err_d   = proto_err_q;

        if (!stall) begin
            mode_d = eff_mode;
            if (weight_load) begin
                weight_d = weight_in;
            end
            if ((eff_mode != mode_q) && (bus.a_in_valid || bus.b_in_valid)) begin
                proto_err_d = 1'b1;
            end

            unique case (eff_mode)
                MODE_WS: begin
                    a_out_valid_d = fire;
                    b_out_valid_d = fire;
                    if (fire) begin
                        a_out_d = bus.a_in;
                        b_out_d = sat_val;
                        if (clamp) begin
                            acc_ovf_d = 1'b1;
                        end
                    end
                end
                MODE_OS: begin
                    if (acc_clear) begin
                        acc_d     = '0;
                        acc_ovf_d = 1'b0;
                    end
                    if (drain) begin
                        // Drain wins over a coincident fire, which is dropped.
                        b_out_d       = acc_q;
                        b_out_valid_d = 1'b1;
                        a_out_valid_d = 1'b0;
                        acc_d         = '0;
                        if (fire) begin
                            proto_err_d = 1'b1;
                        end
                    end else begin
                        a_out_valid_d = fire;
                        b_out_valid_d = fire;
                        if (fire) begin
                            acc_d   = sat_val;
                            a_out_d = bus.a_in;
                            b_out_d = bus.b_in;
                            if (clamp) begin
                                acc_ovf_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    a_out_d       = bus.a_in;
                    b_out_d       = bus.b_in;
                    a_out_valid_d = bus.a_in_valid;
                    b_out_valid_d = bus.b_in_valid;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q        <= MODE_BYP;
            a_out_q       <= '0;
            a_out_valid_q <= 1'b0;
            b_out_q       <= '0;
            b_out_valid_q <= 1'b0;
            acc_q         <= '0;
            weight_q      <= '0;
            acc_ovf_q     <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            a_out_q       <= a_out_d;
            a_out_valid_q <= a_out_valid_d;
            b_out_q       <= b_out_d;
            b_out_valid_q <= b_out_valid_d;
            acc_q         <= acc_d;
            weight_q      <= weight_d;
            acc_ovf_q     <= acc_ovf_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign bus.a_out       = a_out_q;
    assign bus.a_out_valid = a_out_valid_q;
    assign bus.b_out       = b_out_q;
    assign bus.b_out_valid = b_out_valid_q;
    assign acc_ovf         = acc_ovf_q;
    assign proto_err       = proto_err_q;
endmodule

// File: tb/tb_pe_unit_gen2.sv
// Directed bench for pe_unit_gen2: a 24-bit signed PE for the main dataflow
// scenarios and a 16-bit signed PE for saturation.
module tb_pe_unit_gen2;
    logic clk = 1'b0;
    logic reset;

    pe_unit_gen2_if #(.DATA_WIDTH(8), .ACCUM_WIDTH(24)) bus ();
    pe_unit_gen2_if #(.DATA_WIDTH(8), .ACCUM_WIDTH(16)) bus_s ();

    logic [1:0] mode, mode_s;
    logic       stall, stall_s;
    logic [7:0] weight_in, weight_in_s;
    logic       weight_load, weight_load_s;
    logic       acc_clear, acc_clear_s;
    logic       drain, drain_s;
    logic       acc_ovf, acc_ovf_s;
    logic       proto_err, proto_err_s;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pe_unit_gen2 #(.DATA_WIDTH(8), .ACCUM_WIDTH(24), .SIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus), .mode(mode), .stall(stall),
        .weight_in(weight_in), .weight_load(weight_load), .acc_clear(acc_clear),
        .drain(drain), .acc_ovf(acc_ovf), .proto_err(proto_err)
    );

    pe_unit_gen2 #(.DATA_WIDTH(8), .ACCUM_WIDTH(16), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s), .mode(mode_s), .stall(stall_s),
        .weight_in(weight_in_s), .weight_load(weight_load_s), .acc_clear(acc_clear_s),
        .drain(drain_s), .acc_ovf(acc_ovf_s), .proto_err(proto_err_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic av, input logic [23:0] b, input logic bv);
        bus.a_in = a; bus.a_in_valid = av; bus.b_in = b; bus.b_in_valid = bv;
    endtask

    task automatic test_reset();
        mode = 2'd2;
        drive(8'h11, 1'b1, 24'h22, 1'b1);
        tick();
        vectors++; if (bus.a_out !== 8'h11) begin miscompares++; $display("FAIL rst_pre_a_out: got %0h want 11", bus.a_out); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus.a_out !== 8'h0) begin miscompares++; $display("FAIL rst_a_out: got %0h want 0", bus.a_out); end
        vectors++; if (bus.a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_a_out_valid: got %0b want 0", bus.a_out_valid); end
        vectors++; if (bus.b_out !== 24'h0) begin miscompares++; $display("FAIL rst_b_out: got %0h want 0", bus.b_out); end
        vectors++; if (bus.b_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_b_out_valid: got %0b want 0", bus.b_out_valid); end
        vectors++; if (acc_ovf !== 1'b0) begin miscompares++; $display("FAIL rst_acc_ovf: got %0b want 0", acc_ovf); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_proto_err: got %0b want 0", proto_err); end
        #1 reset = 1'b0;
        #1;
        vectors++; if (bus.a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_release_valid: got %0b want 0", bus.a_out_valid); end
        tick();
        vectors++; if (bus.a_out !== 8'h11 || bus.a_out_valid !== 1'b1) begin
            miscompares++; $display("FAIL rst_first_fire: got %0h/%0b want 11/1", bus.a_out, bus.a_out_valid); end
        drive(8'h0, 1'b0, 24'h0, 1'b0);
        tick();
    endtask

    task automatic test_ws();
        mode = 2'd0;
        tick();
        weight_in = 8'd3; weight_load = 1'b1;
        tick();
        weight_in = 8'd7;
        drive(8'd5, 1'b1, 24'd100, 1'b1);
        tick();
        weight_load = 1'b0;
        vectors++; if (bus.b_out !== 24'd115) begin miscompares++; $display("FAIL ws_b_out: got %0d want 115", bus.b_out); end
        vectors++; if (bus.a_out !== 8'd5) begin miscompares++; $display("FAIL ws_a_out: got %0d want 5", bus.a_out); end
        vectors++; if (bus.a_out_valid !== 1'b1 || bus.b_out_valid !== 1'b1) begin
            miscompares++; $display("FAIL ws_valids: got %0b%0b want 11", bus.a_out_valid, bus.b_out_valid); end
        tick();
        vectors++; if (bus.b_out !== 24'd135) begin miscompares++; $display("FAIL ws_new_weight: got %0d want 135", bus.b_out); end
        drive(8'hFE, 1'b1, 24'd10, 1'b1);
        tick();
        vectors++; if (bus.b_out !== 24'hFFFFFC) begin miscompares++; $display("FAIL ws_signed: got %0h want fffffc", bus.b_out); end
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        tick();
        vectors++; if (bus.a_out_valid !== 1'b0 || bus.b_out_valid !== 1'b0 || bus.b_out !== 24'hFFFFFC) begin
            miscompares++; $display("FAIL ws_idle_hold: got %0b%0b %0h want 00 fffffc", bus.a_out_valid, bus.b_out_valid, bus.b_out); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL ws_proto_err: got %0b want 0", proto_err); end
    endtask

    task automatic test_os_accumulate();
        mode = 2'd1;
        tick();
        drive(8'd2, 1'b1, 24'd3, 1'b1);
        tick();
        vectors++; if (bus.b_out !== 24'd3 || bus.a_out !== 8'd2) begin
            miscompares++; $display("FAIL os_passthru: got %0d/%0d want 3/2", bus.b_out, bus.a_out); end
        drive(8'd4, 1'b1, 24'd5, 1'b1);
        tick();
        drive(8'hFF, 1'b1, 24'd6, 1'b1);
        tick();
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        vectors++; if (bus.b_out !== 24'd20 || bus.b_out_valid !== 1'b1) begin
            miscompares++; $display("FAIL os_drain: got %0d/%0b want 20/1", bus.b_out, bus.b_out_valid); end
        vectors++; if (bus.a_out_valid !== 1'b0) begin miscompares++; $display("FAIL os_drain_a_valid: got %0b want 0", bus.a_out_valid); end
        drive(8'd1, 1'b1, 24'd1, 1'b1);
        tick();
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        vectors++; if (bus.b_out !== 24'd1) begin miscompares++; $display("FAIL os_drain_restart: got %0d want 1", bus.b_out); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL os_proto_err: got %0b want 0", proto_err); end
    endtask

    task automatic test_protocol_stall();
        drive(8'd3, 1'b1, 24'd3, 1'b1);
        tick();
        drive(8'd5, 1'b1, 24'd5, 1'b1);
        drain = 1'b1;
        tick();
        vectors++; if (bus.b_out !== 24'd9 || bus.b_out_valid !== 1'b1 || bus.a_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL proto_drain_fire: got %0d/%0b/%0b want 9/1/0", bus.b_out, bus.b_out_valid, bus.a_out_valid); end
        vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL proto_err_set: got %0b want 1", proto_err); end
        drain = 1'b0;
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        tick();
        vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL proto_err_sticky: got %0b want 1", proto_err); end
        drain = 1'b1;
        tick();
        drain = 1'b0;
        vectors++; if (bus.b_out !== 24'd0) begin miscompares++; $display("FAIL proto_fire_dropped: got %0d want 0", bus.b_out); end
        drive(8'd2, 1'b1, 24'd2, 1'b1);
        tick();
        stall = 1'b1;
        drain = 1'b1;
        drive(8'd9, 1'b1, 24'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.a_out !== 8'd2 || bus.b_out !== 24'd2 || bus.b_out_valid !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold[%0d]: got %0d/%0d/%0b want 2/2/1", i, bus.a_out, bus.b_out, bus.b_out_valid); end
        end
        stall = 1'b0;
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        tick();
        drain = 1'b0;
        vectors++; if (bus.b_out !== 24'd4) begin miscompares++; $display("FAIL stall_no_accum: got %0d want 4", bus.b_out); end
    endtask

    task automatic test_bypass();
        drive(8'd3, 1'b1, 24'd4, 1'b1);
        tick();
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        mode = 2'd2;
        tick();
        drive(8'h5A, 1'b1, 24'h123, 1'b0);
        tick();
        vectors++; if (bus.a_out !== 8'h5A || bus.a_out_valid !== 1'b1 || bus.b_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL byp_mode2: got %0h/%0b/%0b want 5a/1/0", bus.a_out, bus.a_out_valid, bus.b_out_valid); end
        mode = 2'd3;
        drive(8'hA5, 1'b1, 24'h321, 1'b0);
        tick();
        vectors++; if (bus.a_out !== 8'hA5 || bus.a_out_valid !== 1'b1 || bus.b_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL byp_mode3: got %0h/%0b/%0b want a5/1/0", bus.a_out, bus.a_out_valid, bus.b_out_valid); end
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        mode = 2'd1;
        tick();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        vectors++; if (bus.b_out !== 24'd12) begin miscompares++; $display("FAIL byp_acc_held: got %0d want 12", bus.b_out); end
    endtask

    task automatic test_saturation();
        mode_s = 2'd1;
        bus_s.a_in = 8'h80; bus_s.a_in_valid = 1'b1;
        bus_s.b_in = 16'h0080; bus_s.b_in_valid = 1'b1;
        tick();
        vectors++; if (acc_ovf_s !== 1'b0 || bus_s.b_out !== 16'h0080) begin
            miscompares++; $display("FAIL sat_first: got %0b/%0h want 0/80", acc_ovf_s, bus_s.b_out); end
        vectors++; if (proto_err_s !== 1'b1) begin miscompares++; $display("FAIL sat_mode_change_err: got %0b want 1", proto_err_s); end
        tick();
        vectors++; if (acc_ovf_s !== 1'b1) begin miscompares++; $display("FAIL sat_ovf: got %0b want 1", acc_ovf_s); end
        bus_s.a_in_valid = 1'b0; bus_s.b_in_valid = 1'b0;
        drain_s = 1'b1;
        tick();
        drain_s = 1'b0;
        vectors++; if (bus_s.b_out !== 16'h7FFF || acc_ovf_s !== 1'b1) begin
            miscompares++; $display("FAIL sat_clamp: got %0h/%0b want 7fff/1", bus_s.b_out, acc_ovf_s); end
        acc_clear_s = 1'b1;
        bus_s.a_in = 8'd2; bus_s.a_in_valid = 1'b1;
        bus_s.b_in = 16'd2; bus_s.b_in_valid = 1'b1;
        tick();
        acc_clear_s = 1'b0;
        vectors++; if (acc_ovf_s !== 1'b0) begin miscompares++; $display("FAIL sat_clear_ovf: got %0b want 0", acc_ovf_s); end
        bus_s.a_in_valid = 1'b0; bus_s.b_in_valid = 1'b0;
        drain_s = 1'b1;
        tick();
        drain_s = 1'b0;
        vectors++; if (bus_s.b_out !== 16'd4) begin miscompares++; $display("FAIL sat_clear_fire: got %0d want 4", bus_s.b_out); end
    endtask

    initial begin
        reset = 1'b1;
        mode = 2'd2; stall = 1'b0; weight_in = '0; weight_load = 1'b0;
        acc_clear = 1'b0; drain = 1'b0;
        mode_s = 2'd2; stall_s = 1'b0; weight_in_s = '0; weight_load_s = 1'b0;
        acc_clear_s = 1'b0; drain_s = 1'b0;
        drive(8'd0, 1'b0, 24'd0, 1'b0);
        bus_s.a_in = '0; bus_s.a_in_valid = 1'b0; bus_s.b_in = '0; bus_s.b_in_valid = 1'b0;
        #12 reset = 1'b0;
        tick();
        test_reset();
        test_ws();
        test_os_accumulate();
        test_protocol_stall();
        test_bypass();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
